// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle HI/LO ALU: funct codes, FSM states
// and the operation select for the iterative multiply/divide engine.
package alu_pkg;

    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) engine.
// One step per clock; start loads the operands, WIDTH steps follow. On the
// final step done is high and hi/lo carry the finished result combinationally
// so the owner can capture it on that same edge.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // hi_r/lo_r form one 2*WIDTH shift register shared by both operations:
    // multiply keeps {partial product, remaining multiplier bits},
    // divide keeps {partial remainder, dividend bits / quotient bits}.
    logic [CNT_W-1:0] cnt;
    md_op_t           op_q;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opnd_r;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // One iteration of the selected algorithm, computed from the current partials.
    always_comb begin
        sum     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
        shifted = {hi_r, lo_r[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd_r});
        // The true difference is below the divisor whenever it is used,
        // so WIDTH bits of wrap-around arithmetic are exact.
        diff    = shifted[WIDTH-1:0] - opnd_r;
        if (op_q == OP_MUL) begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], lo_r[WIDTH-1:1]};
        end else begin
            step_hi = ge ? diff : shifted[WIDTH-1:0];
            step_lo = {lo_r[WIDTH-2:0], ge};
        end
        done = (cnt == CNT_W'(1));
        hi   = step_hi;
        lo   = step_lo;
    end

    // Load operands on start, then advance one step per cycle while the counter runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= OP_MUL;
            hi_r   <= '0;
            lo_r   <= '0;
            opnd_r <= '0;
        end else if (start) begin
            cnt    <= CNT_W'(WIDTH);
            op_q   <= op;
            hi_r   <= '0;
            lo_r   <= (op == OP_MUL) ? b : a;
            opnd_r <= (op == OP_MUL) ? a : b;
        end else if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
            hi_r   <= step_hi;
            lo_r   <= step_lo;
        end
    end

endmodule

// File: rtl/alu_mc_hilo.sv
// Multi-cycle MIPS-funct ALU with HI/LO registers and iterative MULTU/DIVU.
// Handshake: an operation is taken on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, a request seen while busy is dropped (the
// producer holds it), and out_valid is a one-cycle pulse qualifying Output
// and illegal, which otherwise hold their last values.
module alu_mc_hilo
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    output logic [WIDTH-1:0] Output,
    output logic             illegal
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             md_start;
    md_op_t           md_op;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    assign accept = in_valid && in_ready;

    seq_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .op    (md_op),
        .a     (dataA),
        .b     (dataB),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // State register; reset wins over any simultaneous acceptance.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, ready and engine launch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        md_start   = 1'b0;
        md_op      = OP_MUL;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && Signal == FN_MULTU) begin
                    md_start   = 1'b1;
                    state_next = MUL;
                end else if (in_valid && Signal == FN_DIVU) begin
                    md_start   = 1'b1;
                    md_op      = OP_DIV;
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (md_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ALU, shifter and HI/LO moves; unknown codes flag illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (Signal)
            FN_AND:   alu_res = dataA & dataB;
            FN_OR:    alu_res = dataA | dataB;
            FN_ADD:   alu_res = dataA + dataB;
            FN_SUB:   alu_res = dataA - dataB;
            FN_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            FN_SRL:   alu_res = dataA >> dataB[SHAMT_W-1:0];
            FN_MFHI:  alu_res = hi_q;
            FN_MFLO:  alu_res = lo_q;
            FN_MULTU, FN_DIVU: alu_res = '0;
            default:  alu_ill = 1'b1;
        endcase
    end

    // Result register and HI/LO: engine completion or a single-cycle acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            Output    <= '0;
            illegal   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state != IDLE && md_done) begin
                hi_q      <= md_hi;
                lo_q      <= md_lo;
                Output    <= md_lo;
                illegal   <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept && !md_start) begin
                Output    <= alu_res;
                illegal   <= alu_ill;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc_hilo.sv
// Self-checking bench for alu_mc_hilo: directed vector table, hand-written
// multi-cycle sequences, randomized ops against a plain-arithmetic model,
// and a WIDTH=8 instance for the narrow multiply case.
module tb_alu_mc_hilo;
    import alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // 32-bit instance
    logic         in_valid, in_ready, out_valid, illegal;
    logic [W-1:0] dataA, dataB, Output;
    logic [5:0]   Signal;

    alu_mc_hilo #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .Signal    (Signal),
        .out_valid (out_valid),
        .Output    (Output),
        .illegal   (illegal)
    );

    // 8-bit instance
    logic       in_valid8, in_ready8, out_valid8, illegal8;
    logic [7:0] dataA8, dataB8, Output8;
    logic [5:0] Signal8;

    alu_mc_hilo #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .dataA     (dataA8),
        .dataB     (dataB8),
        .Signal    (Signal8),
        .out_valid (out_valid8),
        .Output    (Output8),
        .illegal   (illegal8)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];   // {illegal, result}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] hi_m, lo_m;

    function automatic bit is_legal(input logic [5:0] fn);
        return fn inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL,
                          FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO};
    endfunction

    // Returns {illegal, result} and updates the model HI/LO.
    function automatic logic [W:0] model(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           ill;
        r   = '0;
        ill = 1'b0;
        case (fn)
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_ADD:  r = W'(a + b);
            FN_SUB:  r = W'(a - b);
            FN_SLT:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            FN_SRL:  r = a >> (b % W);
            FN_MFHI: r = hi_m;
            FN_MFLO: r = lo_m;
            FN_MULTU: begin
                p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                hi_m = p[2*W-1:W];
                lo_m = p[W-1:0];
                r    = lo_m;
            end
            FN_DIVU: begin
                if (b == 0) begin
                    lo_m = '1;
                    hi_m = a;
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
                r = lo_m;
            end
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // ---------------- driver ----------------
    // Starts and ends on a falling edge; issues one op, waits for its pulse.
    task automatic run_op(input string name, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp);
        int waitc, lat, busy_bad, lat_exp;
        logic [W:0] e;
        exp_q.push_back(exp);
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        in_valid = 1'b1;
        dataA    = a;
        dataB    = b;
        Signal   = fn;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        busy_bad = 0;
        while (!out_valid && lat < W + 8) begin
            if (in_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        e       = exp_q.pop_front();
        lat_exp = (fn == FN_MULTU || fn == FN_DIVU) ? W + 1 : 1;
        check({name, ".result"}, {out_valid, illegal, Output}, {1'b1, e[W], e[W-1:0]});
        check({name, ".latency"}, lat, lat_exp);
        if (lat_exp > 1) check({name, ".busy_ready"}, busy_bad, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [5:0] fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic       ill;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [5:0] fn, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res, input logic ill);
        vec_t v;
        v.name = n; v.fn = fn; v.a = a; v.b = b; v.res = res; v.ill = ill;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin : main
        logic [W:0] e;
        logic [5:0] fn;
        logic [W-1:0] ra, rb;
        int lat, pulses, busy_bad;
        logic [5:0] fn_pool[10];

        tbl.push_back(mk("add_wrap",  FN_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0));
        tbl.push_back(mk("slt_neg",   FN_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0));
        tbl.push_back(mk("slt_pos",   FN_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
        tbl.push_back(mk("srl_shamt", FN_SRL,  32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 1'b0));
        tbl.push_back(mk("sub_wrap",  FN_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0));
        tbl.push_back(mk("and",       FN_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
        tbl.push_back(mk("or",        FN_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0));
        tbl.push_back(mk("illegal63", 6'd63,   32'h0000_1234, 32'h0000_0005, 32'h0000_0000, 1'b1));
        tbl.push_back(mk("divu_100_7",FN_DIVU, 32'd100,       32'd7,         32'd14,        1'b0));
        tbl.push_back(mk("mfhi_rem",  FN_MFHI, 32'h0,         32'h0,         32'd2,         1'b0));
        tbl.push_back(mk("divu_by0",  FN_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0));
        tbl.push_back(mk("mfhi_by0",  FN_MFHI, 32'h0,         32'h0,         32'd5,         1'b0));
        tbl.push_back(mk("mflo_by0",  FN_MFLO, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0));

        fn_pool = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO};

        // Reset
        reset = 1'b1; in_valid = 1'b0; dataA = '0; dataB = '0; Signal = '0;
        in_valid8 = 1'b0; dataA8 = '0; dataB8 = '0; Signal8 = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {in_ready, out_valid, illegal, Output}, {1'b1, 1'b0, 1'b0, 32'h0});
        reset = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].name, tbl[i].fn, tbl[i].a, tbl[i].b, {tbl[i].ill, tbl[i].res});
            void'(model(tbl[i].fn, tbl[i].a, tbl[i].b));
        end

        // Back-to-back AND then OR: two consecutive pulses
        @(negedge clk);
        in_valid = 1'b1; Signal = FN_AND; dataA = 32'h0000_FFFF; dataB = 32'h00FF_00FF;
        @(negedge clk);
        check("b2b.and", {out_valid, Output}, {1'b1, 32'h0000_00FF});
        Signal = FN_OR;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b.or", {out_valid, Output}, {1'b1, 32'h00FF_FFFF});
        @(negedge clk);
        check("b2b.idle", {out_valid, Output}, {1'b0, 32'h00FF_FFFF});

        // MULTU max*max with MFHI held during busy: new HI read right after
        in_valid = 1'b1; Signal = FN_MULTU; dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
        @(negedge clk);
        Signal = FN_MFHI;
        lat = 1; busy_bad = 0;
        while (!out_valid && lat < W + 8) begin
            if (in_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check("mul_max.latency", lat, W + 1);
        check("mul_max.busy_ready", busy_bad, 0);
        check("mul_max.lo", {out_valid, illegal, Output}, {1'b1, 1'b0, 32'h0000_0001});
        @(negedge clk);
        in_valid = 1'b0;
        check("mul_max.mfhi", {out_valid, Output}, {1'b1, 32'hFFFF_FFFE});
        @(negedge clk);
        check("mul_max.no_extra", out_valid, 1'b0);
        void'(model(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

        // Reset 10 cycles into a MULTU: aborted, no pulse, HI/LO cleared
        in_valid = 1'b1; Signal = FN_MULTU; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.ready", {in_ready, out_valid}, {1'b1, 1'b0});
        pulses = 0;
        for (int c = 0; c < W + 5; c++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        check("abort.no_pulse", pulses, 0);
        hi_m = '0; lo_m = '0;
        run_op("abort.mfhi", FN_MFHI, '0, '0, model(FN_MFHI, '0, '0));
        run_op("abort.mflo", FN_MFLO, '0, '0, model(FN_MFLO, '0, '0));

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do fn = 6'($urandom_range(0, 63)); while (is_legal(fn));
            end else begin
                fn = fn_pool[$urandom_range(0, 9)];
            end
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 15));
                1:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            e = model(fn, ra, rb);
            run_op($sformatf("rand%0d_fn%0d", i, fn), fn, ra, rb, e);
        end

        // WIDTH=8: MULTU 0xFF x 0x02 -> HI=0x01, LO=0xFE
        @(negedge clk);
        in_valid8 = 1'b1; Signal8 = FN_MULTU; dataA8 = 8'hFF; dataB8 = 8'h02;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1; busy_bad = 0;
        while (!out_valid8 && lat < 20) begin
            if (in_ready8) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check("w8_mul.latency", lat, 9);
        check("w8_mul.busy_ready", busy_bad, 0);
        check("w8_mul.lo", {out_valid8, illegal8, Output8}, {1'b1, 1'b0, 8'hFE});
        in_valid8 = 1'b1; Signal8 = FN_MFHI;
        @(negedge clk);
        check("w8_mul.mfhi", {out_valid8, Output8}, {1'b1, 8'h01});
        Signal8 = FN_MFLO;
        @(negedge clk);
        in_valid8 = 1'b0;
        check("w8_mul.mflo", {out_valid8, Output8}, {1'b1, 8'hFE});

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
